// File: rtl/cpu_trace_buffer.sv
// Execution-trace capture buffer: records CPU cycles into a circular memory around a
// trigger event, then replays them oldest-first over a first-word-fall-through port.
module cpu_trace_buffer #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 64,
  parameter int CYCLE_W = 16,
  parameter int PTR_W   = $clog2(DEPTH)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [ADDR_W-1:0]                     pc,
  input  logic [DATA_W-1:0]                     instruction,
  input  logic [DATA_W-1:0]                     alu_result,
  input  logic                                  mem_read,
  input  logic                                  mem_write,
  input  logic                                  reg_write,
  input  logic                                  sample_en,
  input  logic                                  arm,
  input  logic                                  stop,
  input  logic [1:0]                            trig_mode,
  input  logic [ADDR_W-1:0]                     trig_pc,
  input  logic                                  trig_in,
  input  logic [PTR_W-1:0]                      post_len,
  input  logic                                  rd_ready,
  output logic                                  rd_valid,
  output logic [CYCLE_W+3+ADDR_W+2*DATA_W-1:0]  rd_data,
  output logic                                  rd_last,
  output logic                                  busy,
  output logic                                  triggered,
  output logic                                  done
);

  localparam int ENTRY_W = CYCLE_W + 3 + ADDR_W + 2 * DATA_W;
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_POST, S_DONE} state_t;

  state_t               state_reg;
  logic [PTR_W-1:0]     wr_ptr_reg;
  logic [PTR_W-1:0]     rd_ptr_reg;
  logic [PTR_W:0]       count_reg;
  logic [PTR_W:0]       remaining_reg;
  logic [CYCLE_W-1:0]   cycle_reg;
  logic [PTR_W-1:0]     post_cnt_reg;
  logic                 triggered_reg;
  logic                 rd_valid_reg;
  logic                 rd_init_reg;
  logic [ENTRY_W-1:0]   rd_data_reg;

  logic [ENTRY_W-1:0]   mem [DEPTH];

  logic                 capturing;
  logic                 wr_en;
  logic                 trig_hit;
  logic [ENTRY_W-1:0]   sample_entry;
  logic [PTR_W-1:0]     rd_start;
  logic [PTR_W-1:0]     rd_addr;
  logic [ENTRY_W-1:0]   mem_q;

  assign capturing    = (state_reg == S_ARMED) || (state_reg == S_POST);
  assign wr_en        = capturing && sample_en;
  assign sample_entry = {cycle_reg, mem_read, mem_write, reg_write, pc, instruction, alu_result};

  always_comb begin
    trig_hit = 1'b0;
    case (trig_mode)
      2'd0:    trig_hit = 1'b1;
      2'd1:    trig_hit = (pc == trig_pc);
      2'd2:    trig_hit = mem_write;
      default: trig_hit = trig_in;
    endcase
  end

  // Oldest entry sits count slots behind the write pointer; modulo wrap is free for power-of-two DEPTH.
  assign rd_start = wr_ptr_reg - count_reg[PTR_W-1:0];
  assign rd_addr  = rd_init_reg ? rd_start : rd_ptr_reg + 1'b1;
  assign mem_q    = mem[rd_addr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= sample_entry;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      remaining_reg <= '0;
      cycle_reg     <= '0;
      post_cnt_reg  <= '0;
      triggered_reg <= 1'b0;
      rd_valid_reg  <= 1'b0;
      rd_init_reg   <= 1'b0;
      rd_data_reg   <= '0;
    end else begin
      if (capturing && (cycle_reg != '1)) begin
        cycle_reg <= cycle_reg + 1'b1;
      end
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (count_reg != DEPTH_CNT) begin
          count_reg <= count_reg + 1'b1;
        end
      end

      case (state_reg)
        S_IDLE: begin
          if (arm) begin
            state_reg     <= S_ARMED;
            wr_ptr_reg    <= '0;
            count_reg     <= '0;
            cycle_reg     <= '0;
            triggered_reg <= 1'b0;
          end
        end

        S_ARMED: begin
          if (sample_en && trig_hit) begin
            triggered_reg <= 1'b1;
            post_cnt_reg  <= post_len;
            if ((post_len == '0) || stop) begin
              state_reg   <= S_DONE;
              rd_init_reg <= 1'b1;
            end else begin
              state_reg <= S_POST;
            end
          end else if (stop) begin
            state_reg   <= S_DONE;
            rd_init_reg <= 1'b1;
          end
        end

        S_POST: begin
          if (sample_en) begin
            post_cnt_reg <= post_cnt_reg - 1'b1;
            if ((post_cnt_reg == PTR_W'(1)) || stop) begin
              state_reg   <= S_DONE;
              rd_init_reg <= 1'b1;
            end
          end else if (stop) begin
            state_reg   <= S_DONE;
            rd_init_reg <= 1'b1;
          end
        end

        S_DONE: begin
          if (arm) begin
            state_reg     <= S_ARMED;
            wr_ptr_reg    <= '0;
            count_reg     <= '0;
            cycle_reg     <= '0;
            triggered_reg <= 1'b0;
            rd_valid_reg  <= 1'b0;
            rd_init_reg   <= 1'b0;
            remaining_reg <= '0;
          end else if (rd_init_reg) begin
            // First DONE cycle: pointers are final, prefetch the oldest entry.
            rd_init_reg   <= 1'b0;
            rd_ptr_reg    <= rd_start;
            remaining_reg <= count_reg;
            rd_valid_reg  <= (count_reg != '0);
            if (count_reg != '0) begin
              rd_data_reg <= mem_q;
            end
          end else if (rd_valid_reg && rd_ready) begin
            rd_ptr_reg    <= rd_ptr_reg + 1'b1;
            remaining_reg <= remaining_reg - 1'b1;
            if (remaining_reg == (PTR_W + 1)'(1)) begin
              rd_valid_reg <= 1'b0;
            end else begin
              rd_data_reg <= mem_q;
            end
          end
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign rd_valid  = rd_valid_reg;
  assign rd_data   = rd_data_reg;
  assign rd_last   = rd_valid_reg && (remaining_reg == (PTR_W + 1)'(1));
  assign busy      = capturing;
  assign done      = (state_reg == S_DONE);
  assign triggered = triggered_reg;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed bench for cpu_trace_buffer (DEPTH=8): trigger modes, stop, backpressure,
// empty capture and asynchronous reset during POST and readout.
module tb_cpu_trace_buffer;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DEPTH = 8;
  localparam int CW = 16;
  localparam int PW = 3;
  localparam int EW = CW + 3 + AW + 2 * DW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] pc = '0;
  logic [DW-1:0] instruction = '0;
  logic [DW-1:0] alu_result = '0;
  logic          mem_read = 1'b0;
  logic          mem_write = 1'b0;
  logic          reg_write = 1'b0;
  logic          sample_en = 1'b0;
  logic          arm = 1'b0;
  logic          stop = 1'b0;
  logic [1:0]    trig_mode = '0;
  logic [AW-1:0] trig_pc = '0;
  logic          trig_in = 1'b0;
  logic [PW-1:0] post_len = '0;
  logic          rd_ready = 1'b0;
  logic          rd_valid;
  logic [EW-1:0] rd_data;
  logic          rd_last;
  logic          busy;
  logic          triggered;
  logic          done;

  int checks_cnt = 0;
  int errors_cnt = 0;

  logic [EW-1:0] got_q[$];
  logic          last_q[$];

  cpu_trace_buffer #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .CYCLE_W(CW)) dut (
    .clk(clk), .reset(reset), .pc(pc), .instruction(instruction), .alu_result(alu_result),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write), .sample_en(sample_en),
    .arm(arm), .stop(stop), .trig_mode(trig_mode), .trig_pc(trig_pc), .trig_in(trig_in),
    .post_len(post_len), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_last(rd_last), .busy(busy), .triggered(triggered), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic [1:0] mode, input logic [AW-1:0] tpc, input logic [PW-1:0] plen);
    arm = 1'b1; trig_mode = mode; trig_pc = tpc; post_len = plen;
    step();
    arm = 1'b0;
    check_val("arm_busy", 128'(busy), 128'(1));
    check_val("arm_trig_clear", 128'(triggered), 128'(0));
    check_val("arm_done", 128'(done), 128'(0));
    check_val("arm_rd_valid", 128'(rd_valid), 128'(0));
  endtask

  task automatic drive_sample(input logic se, input logic [AW-1:0] p, input logic mw,
                              input logic ti, input logic st);
    sample_en = se; pc = p; instruction = p ^ 32'hDEAD_0000; alu_result = p + 32'h1000;
    mem_write = mw; reg_write = p[2]; trig_in = ti; stop = st;
    step();
    sample_en = 1'b0; mem_write = 1'b0; trig_in = 1'b0; stop = 1'b0;
  endtask

  task automatic read_all(input bit bp, input int max_cycles);
    bit pat[7];
    bit finished;
    bit prev_stall;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    finished = 1'b0;
    prev_stall = 1'b0;
    got_q.delete();
    last_q.delete();
    for (int k = 0; k < max_cycles && !finished; k++) begin
      if (prev_stall) check_val("stall_valid_held", 128'(rd_valid), 128'(1));
      rd_ready = bp ? pat[k % 7] : 1'b1;
      if (rd_valid && rd_ready) begin
        got_q.push_back(rd_data);
        last_q.push_back(rd_last);
        $display("rd idx=%0d pc=%h cyc=%0d mw=%0b last=%0b", got_q.size() - 1,
                 rd_data[95:64], rd_data[114:99], rd_data[97], rd_last);
        if (rd_last) finished = 1'b1;
      end
      prev_stall = rd_valid && !rd_ready;
      step();
    end
    rd_ready = 1'b0;
    if (!finished) check_val("read_timeout", 128'(0), 128'(1));
    else check_val("valid_after_last", 128'(rd_valid), 128'(0));
  endtask

  task automatic check_entries(input string tag, input int n, input logic [31:0] pc0,
                               input logic [31:0] pc_step, input int cyc0, input int cyc_step,
                               input bit mw_last);
    logic [EW-1:0] e;
    logic [31:0]   p;
    check_val({tag, "_n"}, 128'(got_q.size()), 128'(n));
    for (int i = 0; i < n && i < got_q.size(); i++) begin
      e = got_q[i];
      p = pc0 + pc_step * i;
      check_val({tag, "_pc"}, 128'(e[95:64]), 128'(p));
      check_val({tag, "_instr"}, 128'(e[63:32]), 128'(p ^ 32'hDEAD_0000));
      check_val({tag, "_cyc"}, 128'(e[114:99]), 128'(cyc0 + cyc_step * i));
      check_val({tag, "_mw"}, 128'(e[97]), 128'(mw_last && (i == n - 1)));
      check_val({tag, "_last"}, 128'(last_q[i]), 128'(i == n - 1));
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check_val(tag, 128'({rd_valid, rd_last, busy, triggered, done, rd_data}), 128'(0));
  endtask

  initial begin
    int n;
    bit seen;

    step();
    step();
    check_zero_outputs("reset_outputs");
    reset = 1'b0;
    step();

    // Mode 1: PC match at 0x20, two post samples, buffer wraps.
    do_arm(2'd1, 32'h20, 3'd2);
    n = 0;
    while (!done && n < 40) begin
      drive_sample(1'b1, 32'(4 * n), 1'b0, 1'b0, 1'b0);
      n++;
    end
    check_val("t1_samples", 128'(n), 128'(11));
    check_val("t1_triggered", 128'(triggered), 128'(1));
    check_val("t1_busy", 128'(busy), 128'(0));
    read_all(1'b1, 100);
    check_entries("t1", 8, 32'h0C, 32'd4, 3, 1, 1'b0);

    // Mode 0: immediate trigger, three post samples.
    do_arm(2'd0, 32'h0, 3'd3);
    for (int k = 0; k < 10; k++) drive_sample(1'b1, 32'h100 + 32'(4 * k), 1'b0, 1'b0, 1'b0);
    check_val("t2_busy", 128'(busy), 128'(0));
    check_val("t2_done", 128'(done), 128'(1));
    read_all(1'b0, 40);
    check_entries("t2", 4, 32'h100, 32'd4, 0, 1, 1'b0);

    // Mode 2: mem_write on the 5th sample, sample_en toggling.
    do_arm(2'd2, 32'h0, 3'd0);
    for (int k = 0; k < 9; k++) begin
      drive_sample(k % 2 == 0, 32'h200 + 32'(4 * k), k == 8, 1'b0, 1'b0);
      if (k == 7) check_val("t3_not_early", 128'(done), 128'(0));
    end
    check_val("t3_done", 128'(done), 128'(1));
    check_val("t3_triggered", 128'(triggered), 128'(1));
    read_all(1'b1, 60);
    check_entries("t3", 5, 32'h200, 32'd8, 0, 2, 1'b1);

    // Mode 3 never fires; stop arrives together with the third sample.
    do_arm(2'd3, 32'h0, 3'd2);
    drive_sample(1'b1, 32'h300, 1'b0, 1'b0, 1'b0);
    drive_sample(1'b1, 32'h304, 1'b0, 1'b0, 1'b0);
    drive_sample(1'b1, 32'h308, 1'b0, 1'b0, 1'b1);
    check_val("t5_done", 128'(done), 128'(1));
    check_val("t5_triggered", 128'(triggered), 128'(0));
    read_all(1'b0, 40);
    check_entries("t5", 3, 32'h300, 32'd4, 0, 1, 1'b0);

    do_arm(2'd3, 32'h0, 3'd2);
    drive_sample(1'b1, 32'h400, 1'b0, 1'b0, 1'b0);
    drive_sample(1'b1, 32'h404, 1'b0, 1'b0, 1'b0);
    drive_sample(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    check_val("t5b_done", 128'(done), 128'(1));
    read_all(1'b0, 40);
    check_entries("t5b", 2, 32'h400, 32'd4, 0, 1, 1'b0);

    // Empty capture: stop with no samples.
    do_arm(2'd3, 32'h0, 3'd2);
    drive_sample(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    check_val("empty_done", 128'(done), 128'(1));
    rd_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (rd_valid) seen = 1'b1;
      step();
    end
    rd_ready = 1'b0;
    check_val("empty_no_valid", 128'(seen), 128'(0));

    // Asynchronous reset in POST.
    do_arm(2'd0, 32'h0, 3'd5);
    drive_sample(1'b1, 32'h600, 1'b0, 1'b0, 1'b0);
    drive_sample(1'b1, 32'h604, 1'b0, 1'b0, 1'b0);
    check_val("post_busy", 128'(busy), 128'(1));
    #2 reset = 1'b1;
    #1 check_zero_outputs("reset_mid_post");
    step();
    reset = 1'b0;

    // Asynchronous reset while an entry is presented.
    do_arm(2'd0, 32'h0, 3'd1);
    drive_sample(1'b1, 32'h700, 1'b0, 1'b0, 1'b0);
    drive_sample(1'b1, 32'h704, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (!rd_valid && n < 5) begin
      step();
      n++;
    end
    check_val("readout_valid", 128'(rd_valid), 128'(1));
    check_val("readout_pc", 128'(rd_data[95:64]), 128'(32'h700));
    #2 reset = 1'b1;
    #1 check_zero_outputs("reset_mid_readout");
    step();
    reset = 1'b0;
    step();

    // Clean capture after reset.
    do_arm(2'd0, 32'h0, 3'd2);
    drive_sample(1'b1, 32'h500, 1'b0, 1'b0, 1'b0);
    drive_sample(1'b1, 32'h504, 1'b0, 1'b0, 1'b0);
    drive_sample(1'b1, 32'h508, 1'b0, 1'b0, 1'b0);
    check_val("t6_done", 128'(done), 128'(1));
    read_all(1'b1, 40);
    check_entries("t6", 3, 32'h500, 32'd4, 0, 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/cpu_trace_buffer.md
Name: cpu_trace_buffer

Overview:
Parametrised, synthesizable execution-trace capture block that sits beside the CPU core. It samples PC, instruction, ALU result and the MemRead/MemWrite/RegWrite strobes into a circular buffer. Capture stops a programmable number of samples after a trigger event. The buffer is then streamed out oldest-first over a valid/ready port, so on-chip debug logic and benches can replay the last DEPTH retired cycles without per-cycle console printing.

Parameters:
ADDR_W, 32, PC width
DATA_W, 32, instruction and ALU result width
DEPTH, 64, trace entries; power of two, at least 4
CYCLE_W, 16, timestamp width
PTR_W, $clog2(DEPTH), buffer pointer width (derived; do not override)

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
pc  in  ADDR_W  CPU program counter
instruction  in  DATA_W  current instruction
alu_result  in  DATA_W  ALU output
mem_read  in  1  CPU MemRead
mem_write  in  1  CPU MemWrite
reg_write  in  1  CPU RegWrite
sample_en  in  1  current cycle is a valid CPU cycle to record
arm  in  1  single-cycle pulse: start a new capture
stop  in  1  single-cycle pulse: abort capture, keep contents
trig_mode  in  2  0=immediate, 1=PC match, 2=mem_write, 3=external
trig_pc  in  ADDR_W  PC value compared in mode 1
trig_in  in  1  external trigger for mode 3
post_len  in  PTR_W  samples to record after the trigger sample
rd_ready  in  1  consumer accepts rd_data
rd_valid  out  1  rd_data holds a trace entry
rd_data  out  CYCLE_W+3+ADDR_W+2*DATA_W  entry, packed {cycle, mem_read, mem_write, reg_write, pc, instruction, alu_result}
rd_last  out  1  rd_data is the final (newest) entry
busy  out  1  state is ARMED or POST
triggered  out  1  trigger fired in the current or most recent capture
done  out  1  state is DONE

Behaviour:
- Reset (asynchronous): state IDLE; wr_ptr, rd_ptr, count, cycle and post_cnt = 0. All outputs 0, including rd_data.
- States: IDLE, ARMED, POST, DONE. busy and done decode from the state register.
- arm:
  - In IDLE or DONE: go to ARMED next edge. Clear wr_ptr, count, cycle and triggered. Any in-progress readout is discarded.
  - In ARMED or POST: ignored.
- cycle counter: increments every clk while in ARMED or POST, whether or not sample_en is set. Saturates at all-ones and does not wrap.
- ARMED:
  - Each sample_en=1 cycle writes {cycle, strobes, pc, instruction, alu_result} to mem[wr_ptr].
  - wr_ptr wraps DEPTH-1 -> 0. count saturates at DEPTH; once full, new entries overwrite the oldest.
- Trigger: evaluated only in ARMED, only when sample_en=1, using the same-cycle inputs.
  - Conditions by mode: 0 fires on the first sample; 1 fires when pc==trig_pc; 2 fires when mem_write=1; 3 fires when trig_in=1.
  - The trigger sample itself is written.
  - On trigger: triggered<=1 and post_cnt<=min(post_len, DEPTH-1).
  - If the loaded value is 0, go to DONE; otherwise go to POST.
- POST:
  - Each sample_en=1 cycle writes an entry and decrements post_cnt.
  - The write that takes post_cnt to 0 moves the state to DONE.
  - sample_en=0 cycles write nothing and do not decrement.
- stop in ARMED or POST: go to DONE next edge. If sample_en is also set that cycle, the sample is written first. triggered keeps its value. stop in IDLE or DONE is ignored.
- DONE readout:
  - On entry, rd_ptr = (wr_ptr - count) mod DEPTH and remaining = count.
  - rd_valid asserts on the cycle after entering DONE if count>0. Readout is first-word-fall-through: rd_data is valid whenever rd_valid=1.
  - A transfer occurs on rd_valid && rd_ready: rd_ptr increments with wrap, remaining decrements, and the next entry is presented on the following cycle with no bubble.
  - rd_last = rd_valid && remaining==1.
  - After the final transfer: rd_valid=0, rd_data holds its last value, and the state stays DONE.
  - rd_valid/rd_data must be held stable while rd_ready=0.
  - count==0 in DONE: rd_valid never asserts.
- Memory: single write port plus single read port, with synchronous write. The read may be combinational or a registered prefetch, but the FWFT timing above is mandatory.
- Reset mid-capture or mid-readout: immediate return to IDLE with all outputs 0; buffer contents are don't-care.

Test Plan:
- DEPTH=8, mode 1, trig_pc=0x20, post_len=2, sample_en=1, pc=0,4,8,...
  -> DONE after the pc=0x28 sample; 8 entries read with pc 0x0C..0x28 ascending; rd_last only on 0x28; triggered=1.
- Mode 0, post_len=3, sample_en=1 for 10 cycles with pc=0x100+4n
  -> 4 entries (0x100..0x10C); cycle fields strictly increasing; busy low from DONE onward.
- Mode 2 with mem_write=1 at the 5th sample, post_len=0, sample_en toggling 1,0 each cycle
  -> capture ends on that sample; 5 entries; cycle fields differ by 2; mem_write flag set only in the last entry.
- Readout backpressure: rd_ready pattern 1,0,0,1,1,0,1...
  -> rd_data stable while stalled; no entry dropped or duplicated; rd_valid falls right after the rd_last transfer.
- Mode 3 with trig_in never asserted, stop after 3 samples
  -> DONE with 3 entries; triggered=0. Then arm again -> state ARMED, triggered=0, a fresh capture overwrites.
- Reset asserted mid-POST and mid-readout
  -> all outputs 0 asynchronously; state IDLE; arm afterwards starts a clean capture.
